// File: rtl/scalar_result_buffer_pkg.sv
// Shared codes for the scalar result buffer: ALU sign codes, branch condition
// codes and the occupancy state encoding.
package scalar_result_buffer_pkg;

  localparam logic [1:0] SIGN_POS  = 2'b00;
  localparam logic [1:0] SIGN_ZERO = 2'b01;
  localparam logic [1:0] SIGN_NEG  = 2'b10;

  localparam logic [2:0] BR_BEQ = 3'b000;
  localparam logic [2:0] BR_BNE = 3'b001;
  localparam logic [2:0] BR_BLT = 3'b100;
  localparam logic [2:0] BR_BGE = 3'b101;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } buf_state_e;

endpackage

// File: rtl/scalar_result_buffer_branch_cond.sv
// Combinational branch resolution from the ALU sign code and the branch
// condition code; unknown condition codes are never taken.
module scalar_branch_cond
  import scalar_result_buffer_pkg::*;
(
  input  logic       is_branch,
  input  logic [2:0] branch_cond,
  input  logic [1:0] sign_bits,
  output logic       taken
);

  logic cond_met;

  always_comb begin
    cond_met = 1'b0;
    case (branch_cond)
      BR_BEQ:  cond_met = (sign_bits == SIGN_ZERO);
      BR_BNE:  cond_met = (sign_bits != SIGN_ZERO);
      BR_BLT:  cond_met = (sign_bits == SIGN_NEG);
      BR_BGE:  cond_met = (sign_bits != SIGN_NEG);
      default: cond_met = 1'b0;
    endcase
  end

  assign taken = is_branch && cond_met;

endmodule

// File: rtl/scalar_result_buffer.sv
// Two-entry result buffer between the scalar ALU and writeback; branches are
// resolved on entry. Define SCALAR_BUF_STAT_EN to add taken/stall counters.
module scalar_result_buffer
  import scalar_result_buffer_pkg::*;
#(
  parameter int SCALAR_REG_LEN = 64,
  parameter int DATA_LEN       = 32,
  parameter int REG_INDEX_LEN  = 5
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [SCALAR_REG_LEN-1:0] alu_result,
  input  logic [1:0]                sign_bits,
  input  logic                      is_branch,
  input  logic [2:0]                branch_cond,
  input  logic [DATA_LEN-1:0]       branch_target,
  input  logic [REG_INDEX_LEN-1:0]  rd_index,
  input  logic                      reg_write,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [SCALAR_REG_LEN-1:0] wb_result,
  output logic [REG_INDEX_LEN-1:0]  wb_rd,
  output logic                      wb_reg_write,
  output logic                      branch_taken,
  output logic [DATA_LEN-1:0]       redirect_pc
`ifdef SCALAR_BUF_STAT_EN
  ,
  output logic [31:0]               stat_taken_cnt,
  output logic [31:0]               stat_stall_cnt
`endif
);

  typedef struct packed {
    logic [SCALAR_REG_LEN-1:0] res;
    logic [REG_INDEX_LEN-1:0]  rd;
    logic                      we;
    logic                      tk;
    logic [DATA_LEN-1:0]       pc;
  } entry_t;

  buf_state_e state_q, state_d;
  entry_t     slot_q [2];
  entry_t     new_entry;
  logic       new_taken;
  logic       push, pop;

  scalar_branch_cond u_branch_cond (
    .is_branch   (is_branch),
    .branch_cond (branch_cond),
    .sign_bits   (sign_bits),
    .taken       (new_taken)
  );

  // in_ready/out_valid depend only on registered state
  assign in_ready  = (state_q != ST_FULL);
  assign out_valid = (state_q != ST_EMPTY);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_comb begin
    new_entry.res = alu_result;
    new_entry.rd  = rd_index;
    new_entry.we  = reg_write && !is_branch;
    new_entry.tk  = new_taken;
    new_entry.pc  = new_taken ? branch_target : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_EMPTY;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: if (push) state_d = ST_ONE;
        ST_ONE: begin
          if (push && !pop)      state_d = ST_FULL;
          else if (pop && !push) state_d = ST_EMPTY;
        end
        ST_FULL:  if (pop) state_d = ST_ONE;
        default:  state_d = ST_EMPTY;
      endcase
    end
  end

  // slot 0 is always the head; payload is qualified by state, so no reset
  always_ff @(posedge clk) begin
    case (state_q)
      ST_EMPTY: if (push) slot_q[0] <= new_entry;
      ST_ONE: begin
        if (push && pop) slot_q[0] <= new_entry;
        else if (push)   slot_q[1] <= new_entry;
      end
      ST_FULL:  if (pop) slot_q[0] <= slot_q[1];
      default: ;
    endcase
  end

  assign wb_result    = out_valid ? slot_q[0].res : '0;
  assign wb_rd        = out_valid ? slot_q[0].rd  : '0;
  assign wb_reg_write = out_valid && slot_q[0].we;
  assign branch_taken = out_valid && slot_q[0].tk;
  assign redirect_pc  = out_valid ? slot_q[0].pc  : '0;

`ifdef SCALAR_BUF_STAT_EN
  // a pop cancelled by flush does not count as a retired taken branch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_taken_cnt <= '0;
      stat_stall_cnt <= '0;
    end else begin
      if (pop && !flush && slot_q[0].tk) stat_taken_cnt <= stat_taken_cnt + 32'd1;
      if (in_valid && !in_ready)         stat_stall_cnt <= stat_stall_cnt + 32'd1;
    end
  end
`endif

endmodule
